fractal_sync_fifo: RTL

Single-clock synchronous FIFO that feeds `fractal_sync_arbiter` on the producer side. Each arbiter input port is backed by one instance. The block accepts elements on a push interface and presents them on the `empty` / `element` / `pop` interface the arbiter consumes. The head element is visible combinationally and is popped in the same cycle it is granted. Sticky error flags report protocol misuse to the surrounding sync network.

---
 rtl/fractal_sync_fifo_if.sv | 32 +++
 rtl/fractal_sync_fifo.sv | 121 ++++++++++++
 2 files changed

// File: rtl/fractal_sync_fifo_if.sv
// Push/pop bus between a producer, a fractal_sync_fifo and the arbiter input it feeds.
interface fractal_sync_fifo_if #(
    parameter int unsigned DEPTH  = 4,
    parameter type         fifo_t = logic
) ();

    localparam int unsigned USAGE_W = $clog2(DEPTH + 1);

    logic               flush_i;
    logic               push_i;
    fifo_t              element_i;
    logic               full_o;
    logic               pop_i;
    logic               empty_o;
    fifo_t              element_o;
    logic [USAGE_W-1:0] usage_o;
    logic               overflow_o;
    logic               underflow_o;

    // Producer/arbiter side: drives requests, observes status and head element.
    modport master (
        output flush_i, push_i, element_i, pop_i,
        input  full_o, empty_o, element_o, usage_o, overflow_o, underflow_o
    );

    // FIFO side.
    modport slave (
        input  flush_i, push_i, element_i, pop_i,
        output full_o, empty_o, element_o, usage_o, overflow_o, underflow_o
    );

endinterface

// File: rtl/fractal_sync_fifo.sv
// Single-clock FIFO in front of a fractal_sync_arbiter input port, with an
// optional fall-through bypass and sticky overflow/underflow error flags.
module fractal_sync_fifo #(
    parameter int unsigned DEPTH        = 4,
    parameter bit          FALL_THROUGH = 1'b0,
    parameter type         fifo_t       = logic
) (
    input logic                clk_i,
    input logic                rst_i,
    fractal_sync_fifo_if.slave bus
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    // A zero-entry FIFO has no meaningful behaviour; stop elaboration.
    if (DEPTH == 0) begin : g_bad_depth
        $fatal(1, "fractal_sync_fifo: DEPTH must be at least 1");
    end

    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             empty_q;
    logic             full_q;
    logic             overflow_q;
    logic             underflow_q;
    fifo_t            mem_q [DEPTH];

    logic             bypass_c;
    logic             through_c;
    logic             empty_c;
    logic             pop_accept_c;
    logic             push_accept_c;
    logic             do_push_c;
    logic             do_pop_c;
    logic             ovf_set_c;
    logic             unf_set_c;
    logic [CNT_W-1:0] count_next_c;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + PTR_W'(1);
    endfunction

    // Handshake decode: bypass, acceptance, and which side actually touches storage.
    always_comb begin
        bypass_c      = FALL_THROUGH && empty_q && bus.push_i;
        empty_c       = empty_q && !bypass_c;
        pop_accept_c  = bus.pop_i && !empty_c;
        push_accept_c = bus.push_i && (!full_q || pop_accept_c);
        // Bypassed element goes straight from element_i to the arbiter.
        through_c     = bypass_c && bus.pop_i;
        do_push_c     = push_accept_c && !through_c;
        do_pop_c      = pop_accept_c && !through_c;
        ovf_set_c     = bus.push_i && !push_accept_c;
        unf_set_c     = bus.pop_i && !pop_accept_c;
    end

    // Occupancy after this cycle's accepted push/pop.
    always_comb begin
        count_next_c = count_q;
        if (do_push_c && !do_pop_c) begin
            count_next_c = count_q + CNT_W'(1);
        end else if (do_pop_c && !do_push_c) begin
            count_next_c = count_q - CNT_W'(1);
        end
    end

    // Control state: reset and flush both return to empty with clear flags.
    always_ff @(posedge clk_i) begin
        if (rst_i || bus.flush_i) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (do_push_c) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop_c) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q     <= count_next_c;
            empty_q     <= (count_next_c == '0);
            full_q      <= (count_next_c == CNT_W'(DEPTH));
            overflow_q  <= overflow_q | ovf_set_c;
            underflow_q <= underflow_q | unf_set_c;
        end
    end

    // Storage is not reset; empty masking keeps stale contents invisible.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !bus.flush_i && do_push_c) begin
            mem_q[wr_ptr_q] <= bus.element_i;
        end
    end

    // Output drive: head element masked to zero whenever nothing is readable.
    always_comb begin
        bus.full_o      = full_q;
        bus.empty_o     = empty_c;
        bus.usage_o     = count_q;
        bus.overflow_o  = overflow_q;
        bus.underflow_o = underflow_q;
        if (empty_c) begin
            bus.element_o = '0;
        end else if (bypass_c) begin
            bus.element_o = bus.element_i;
        end else begin
            bus.element_o = mem_q[rd_ptr_q];
        end
    end

endmodule
